// File: rtl/vx_stream_packet_arb.sv
// vx_stream_packet_arb: grouped N-to-M stream arbiter with packet locking and
// an optional 2-entry skid buffer on each output.
module vx_stream_packet_arb #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 1,
    parameter int DATAW       = 32,
    parameter     TYPE        = "R",
    parameter bit LOCK_ENABLE = 1'b1,
    parameter bit BUFFERED    = 1'b0,
    localparam int R    = NUM_INPUTS / NUM_OUTPUTS,
    localparam int SELW = (R > 1) ? $clog2(R) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]   data_in,
    input  logic [NUM_INPUTS-1:0]         last_in,
    output logic [NUM_INPUTS-1:0]         ready_in,
    output logic [NUM_OUTPUTS-1:0]        valid_out,
    output logic [NUM_OUTPUTS*DATAW-1:0]  data_out,
    output logic [NUM_OUTPUTS-1:0]        last_out,
    output logic [NUM_OUTPUTS*SELW-1:0]   sel_out,
    input  logic [NUM_OUTPUTS-1:0]        ready_out
);
    localparam bit RR = (TYPE == "R");
    localparam int PW = DATAW + 1 + SELW;

    if (NUM_INPUTS % NUM_OUTPUTS != 0) begin : g_bad_split
        $error("vx_stream_packet_arb: NUM_INPUTS must be a multiple of NUM_OUTPUTS");
    end
    if (TYPE != "R" && TYPE != "P") begin : g_bad_type
        $error("vx_stream_packet_arb: TYPE must be \"R\" or \"P\"");
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_grp
        logic [R-1:0]     vg, lg;
        logic [DATAW-1:0] dg [R];
        logic [SELW-1:0]  sel_idx;
        logic             sel_valid, sel_last, sel_ready, hs;
        logic [PW-1:0]    sel_pl, out_pl;
        logic             out_v;

        assign vg = valid_in[g*R +: R];
        assign lg = last_in[g*R +: R];
        for (genvar i = 0; i < R; i++) begin : g_unpack
            assign dg[i] = data_in[(g*R+i)*DATAW +: DATAW];
        end

        if (R == 1) begin : g_single
            assign sel_idx   = '0;
            assign sel_valid = vg[0];
        end else begin : g_arb
            localparam logic [SELW:0] RW = (SELW+1)'(R);
            logic            lock_valid_q, lock_valid_d;
            logic [SELW-1:0] lock_idx_q, lock_idx_d, rr_ptr_q, rr_ptr_d;
            logic [SELW-1:0] pick, base, nxt;
            logic [SELW:0]   j;
            logic            any;

            // Scan from the lowest priority up so the highest-priority requester is written last.
            always_comb begin
                base = RR ? rr_ptr_q : '0;
                pick = '0;
                any  = 1'b0;
                j    = '0;
                for (int k = R - 1; k >= 0; k--) begin
                    j = {1'b0, base} + (SELW+1)'(k);
                    j = (j >= RW) ? j - RW : j;
                    if (vg[j[SELW-1:0]]) begin
                        pick = j[SELW-1:0];
                        any  = 1'b1;
                    end
                end
            end

            assign sel_idx   = lock_valid_q ? lock_idx_q : pick;
            assign sel_valid = lock_valid_q ? vg[lock_idx_q] : any;
            assign nxt       = (sel_idx == SELW'(R-1)) ? '0 : sel_idx + 1'b1;

            always_comb begin
                lock_valid_d = hs ? (LOCK_ENABLE && !sel_last) : lock_valid_q;
                lock_idx_d   = hs ? sel_idx : lock_idx_q;
                rr_ptr_d     = (RR && hs && (sel_last || !LOCK_ENABLE)) ? nxt : rr_ptr_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lock_valid_q <= 1'b0;
                    lock_idx_q   <= '0;
                    rr_ptr_q     <= '0;
                end else begin
                    lock_valid_q <= lock_valid_d;
                    lock_idx_q   <= lock_idx_d;
                    rr_ptr_q     <= rr_ptr_d;
                end
            end
        end

        assign sel_last = lg[sel_idx];
        assign sel_pl   = {dg[sel_idx], sel_last, sel_idx};
        assign hs       = sel_valid & sel_ready;
        assign ready_in[g*R +: R] = hs ? R'(1) << sel_idx : '0;

        if (BUFFERED) begin : g_buf
            logic          out_v_q, out_v_d, skid_v_q, skid_v_d, pop, load;
            logic [PW-1:0] out_q, out_d, skid_q, skid_d;

            // Upstream ready depends only on skid occupancy, cutting the ready_out path.
            assign sel_ready = !skid_v_q;
            assign pop       = out_v_q & ready_out[g];
            assign load      = !out_v_q || pop;

            always_comb begin
                out_v_d  = load ? (skid_v_q || hs) : out_v_q;
                out_d    = load ? (skid_v_q ? skid_q : sel_pl) : out_q;
                skid_v_d = load ? 1'b0 : (skid_v_q || hs);
                skid_d   = (!load && hs) ? sel_pl : skid_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_v_q  <= 1'b0;
                    skid_v_q <= 1'b0;
                    out_q    <= '0;
                    skid_q   <= '0;
                end else begin
                    out_v_q  <= out_v_d;
                    skid_v_q <= skid_v_d;
                    out_q    <= out_d;
                    skid_q   <= skid_d;
                end
            end

            assign out_v  = out_v_q;
            assign out_pl = out_q;
        end else begin : g_pass
            assign sel_ready = ready_out[g];
            assign out_v     = sel_valid;
            assign out_pl    = sel_pl;
        end

        assign valid_out[g] = out_v;
        assign {data_out[g*DATAW +: DATAW], last_out[g], sel_out[g*SELW +: SELW]} = out_pl;
    end
endmodule

// File: tb/tb_vx_stream_packet_arb.sv
// tb_vx_stream_packet_arb: three arbiter configurations driven by directed and random
// flit traffic, each output compared every cycle against a behavioural model.
module tb_vx_stream_packet_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // dut_a: 4->1 round-robin passthrough, dut_c: 4->1 fixed priority, dut_b: 8->2 buffered
    logic [3:0]   va, la, ra, vc, lc, rc;
    logic [63:0]  da, dc;
    logic         voa, loa, roa, voc, loc, roc;
    logic [15:0]  doa, doc;
    logic [1:0]   soa, soc;
    logic [7:0]   vb, lb, rb;
    logic [127:0] db;
    logic [1:0]   vob, lob, rob;
    logic [31:0]  dob;
    logic [3:0]   sob;

    vx_stream_packet_arb #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .DATAW(16), .TYPE("R"),
                           .LOCK_ENABLE(1'b1), .BUFFERED(1'b0)) dut_a (
        .clk(clk), .reset(reset), .valid_in(va), .data_in(da), .last_in(la), .ready_in(ra),
        .valid_out(voa), .data_out(doa), .last_out(loa), .sel_out(soa), .ready_out(roa));

    vx_stream_packet_arb #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .DATAW(16), .TYPE("P"),
                           .LOCK_ENABLE(1'b1), .BUFFERED(1'b0)) dut_c (
        .clk(clk), .reset(reset), .valid_in(vc), .data_in(dc), .last_in(lc), .ready_in(rc),
        .valid_out(voc), .data_out(doc), .last_out(loc), .sel_out(soc), .ready_out(roc));

    vx_stream_packet_arb #(.NUM_INPUTS(8), .NUM_OUTPUTS(2), .DATAW(16), .TYPE("R"),
                           .LOCK_ENABLE(1'b1), .BUFFERED(1'b1)) dut_b (
        .clk(clk), .reset(reset), .valid_in(vb), .data_in(db), .last_in(lb), .ready_in(rb),
        .valid_out(vob), .data_out(dob), .last_out(lob), .sel_out(sob), .ready_out(rob));

    // Model units: 0=dut_a, 1=dut_c, 2=dut_b group 0, 3=dut_b group 1
    logic        uv [4][4];
    logic        ul [4][4];
    logic [15:0] ud [4][4];
    logic        ro [4];
    bit          fixed_p [4];
    bit          buf_u [4];
    bit          hsu [4];
    int          lk [4], li [4], ptr [4], gr [4], qn [4];
    logic [18:0] qd [4][2];
    int          ntests = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Highest-priority requester by the arbitration rules, -1 when nothing is granted.
    function automatic int pick(input int u);
        int i;
        if (lk[u] != 0) return uv[u][li[u]] ? li[u] : -1;
        for (int k = 0; k < 4; k++) begin
            i = fixed_p[u] ? k : (ptr[u] + k) % 4;
            if (uv[u][i]) return i;
        end
        return -1;
    endfunction

    task automatic check_unit(input int u);
        logic v, l, ev;
        logic [15:0] d;
        logic [1:0] s;
        logic [3:0] r, er;
        logic [18:0] ep;
        bit rdy;
        case (u)
            0: begin v = voa; d = doa; l = loa; s = soa; r = ra; end
            1: begin v = voc; d = doc; l = loc; s = soc; r = rc; end
            2: begin v = vob[0]; d = dob[15:0]; l = lob[0]; s = sob[1:0]; r = rb[3:0]; end
            default: begin v = vob[1]; d = dob[31:16]; l = lob[1]; s = sob[3:2]; r = rb[7:4]; end
        endcase
        gr[u] = pick(u);
        rdy = buf_u[u] ? (qn[u] < 2) : ro[u];
        er = (gr[u] >= 0 && rdy) ? 4'(1 << gr[u]) : 4'd0;
        ev = buf_u[u] ? (qn[u] > 0) : (gr[u] >= 0);
        ep = qd[u][0];
        if (!buf_u[u] && gr[u] >= 0) ep = {ud[u][gr[u]], ul[u][gr[u]], 2'(gr[u])};
        chk($sformatf("u%0d ready_in", u), 32'(r), 32'(er));
        chk($sformatf("u%0d valid_out", u), 32'(v), 32'(ev));
        if (ev) chk($sformatf("u%0d data/last/sel", u), 32'({d, l, s}), 32'(ep));
        hsu[u] = (gr[u] >= 0) && rdy;
    endtask

    task automatic pre();
        for (int i = 0; i < 4; i++) begin
            va[i] = uv[0][i]; la[i] = ul[0][i]; da[i*16 +: 16] = ud[0][i];
            vc[i] = uv[1][i]; lc[i] = ul[1][i]; dc[i*16 +: 16] = ud[1][i];
            vb[i] = uv[2][i]; lb[i] = ul[2][i]; db[i*16 +: 16] = ud[2][i];
            vb[4+i] = uv[3][i]; lb[4+i] = ul[3][i]; db[64+i*16 +: 16] = ud[3][i];
        end
        roa = ro[0];
        roc = ro[1];
        rob = {ro[3], ro[2]};
        #2;
        for (int u = 0; u < 4; u++) check_unit(u);
    endtask

    task automatic post(input bit rnd);
        @(posedge clk);
        for (int u = 0; u < 4; u++) begin
            if (reset) begin
                lk[u] = 0; ptr[u] = 0; qn[u] = 0;
            end else begin
                if (buf_u[u] && qn[u] > 0 && ro[u]) begin
                    qd[u][0] = qd[u][1];
                    qn[u]--;
                end
                if (hsu[u]) begin
                    if (buf_u[u]) begin
                        qd[u][qn[u]] = {ud[u][gr[u]], ul[u][gr[u]], 2'(gr[u])};
                        qn[u]++;
                    end
                    if (ul[u][gr[u]]) begin
                        lk[u] = 0;
                        if (!fixed_p[u]) ptr[u] = (gr[u] + 1) % 4;
                    end else begin
                        lk[u] = 1;
                        li[u] = gr[u];
                    end
                end
            end
            if (rnd) begin
                for (int i = 0; i < 4; i++) begin
                    if ((hsu[u] && gr[u] == i) || !uv[u][i]) begin
                        uv[u][i] = ($urandom_range(0, 2) != 0);
                        ul[u][i] = ($urandom_range(0, 2) == 0);
                        ud[u][i] = 16'($urandom);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int u = 0; u < 4; u++)
            for (int i = 0; i < 4; i++) begin
                uv[u][i] = 1'b0; ul[u][i] = 1'b0; ud[u][i] = 16'(u * 16 + i);
            end
    endtask

    initial begin
        clear_inputs();
        for (int u = 0; u < 4; u++) begin
            ro[u] = 1'b1; lk[u] = 0; li[u] = 0; ptr[u] = 0; qn[u] = 0; gr[u] = -1;
            hsu[u] = 1'b0; qd[u][0] = '0; qd[u][1] = '0;
            buf_u[u] = (u >= 2); fixed_p[u] = (u == 1);
        end
        va = '0; la = '0; da = '0; vc = '0; lc = '0; dc = '0; vb = '0; lb = '0; db = '0;
        roa = 1'b1; roc = 1'b1; rob = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        pre();
        chk("reset valid_out_a", 32'(voa), 32'd0);
        chk("reset valid_out_b", 32'(vob), 32'd0);
        chk("reset sel_out_b", 32'(sob), 32'd0);
        chk("reset last_out_b", 32'(lob), 32'd0);
        post(0);

        // T1: all valid, single-flit packets -> sel 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) begin uv[0][i] = 1'b1; ul[0][i] = 1'b1; end
        for (int k = 0; k < 8; k++) begin
            pre();
            chk("T1 sel_out", 32'(soa), 32'(k % 4));
            post(0);
        end
        clear_inputs();

        // T2: in0 3-flit packet holds the grant while in1 waits
        uv[0][1] = 1'b1; ul[0][1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            uv[0][0] = (k < 3); ul[0][0] = (k == 2); ud[0][0] = 16'(16'h100 + k);
            pre();
            chk("T2 sel_out", 32'(soa), (k < 3) ? 32'd0 : 32'd1);
            if (k < 3) chk("T2 ready_in1", 32'(ra[1]), 32'd0);
            post(0);
        end
        clear_inputs();

        // T3: locked in2 drops valid mid-packet, in3 must stall
        uv[0][3] = 1'b1; ul[0][3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            uv[0][2] = (k == 0 || k == 3); ul[0][2] = (k == 3);
            pre();
            if (k == 1 || k == 2) begin
                chk("T3 stall valid_out", 32'(voa), 32'd0);
                chk("T3 stall ready_in3", 32'(ra[3]), 32'd0);
            end else chk("T3 sel_out", 32'(soa), (k == 4) ? 32'd3 : 32'd2);
            post(0);
        end
        clear_inputs();

        // T5: fixed priority starves in3
        uv[1][1] = 1'b1; ul[1][1] = 1'b1; uv[1][3] = 1'b1; ul[1][3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pre();
            chk("T5 sel_out", 32'(soc), 32'd1);
            chk("T5 ready_in3", 32'(rc[3]), 32'd0);
            post(0);
        end
        clear_inputs();

        // T4: buffered, ready_out[0] toggles, group 1 saturated
        for (int i = 0; i < 4; i++) begin uv[3][i] = 1'b1; ul[3][i] = ($urandom_range(0, 1) == 1); end
        for (int k = 0; k < 40; k++) begin
            ro[0] = ($urandom_range(0, 3) != 0); ro[1] = ($urandom_range(0, 3) != 0);
            ro[2] = (k % 2 == 0); ro[3] = 1'b1;
            pre();
            if (k >= 1) chk("T4 out1 sustained", 32'(vob[1]), 32'd1);
            post(1);
            for (int i = 0; i < 4; i++)
                if (!uv[3][i]) begin uv[3][i] = 1'b1; ud[3][i] = 16'($urandom); end
        end

        // Random traffic on every unit
        for (int k = 0; k < 300; k++) begin
            for (int u = 0; u < 4; u++) ro[u] = ($urandom_range(0, 3) != 0);
            pre();
            post(1);
        end

        // Drain: every idle input becomes a single-flit packet so all locks end
        for (int u = 0; u < 4; u++) ro[u] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            pre();
            post(0);
            for (int u = 0; u < 4; u++)
                for (int i = 0; i < 4; i++)
                    if ((hsu[u] && gr[u] == i) || !uv[u][i]) begin
                        uv[u][i] = 1'b1; ul[u][i] = 1'b1; ud[u][i] = 16'($urandom);
                    end
        end
        clear_inputs();

        // T6: reset with group 0 locked on in1 and its skid buffer full
        uv[2][1] = 1'b1; ul[2][1] = 1'b0; ro[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pre();
            post(0);
        end
        pre();
        chk("T6 full ready_in1", 32'(rb[1]), 32'd0);
        reset = 1'b1;
        post(0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin uv[2][i] = 1'b1; ul[2][i] = 1'b1; end
        ro[2] = 1'b1;
        pre();
        chk("T6 post-reset valid_out0", 32'(vob[0]), 32'd0);
        chk("T6 post-reset ready_in", 32'(rb[3:0]), 32'd1);
        post(0);
        pre();
        chk("T6 post-reset valid_out0 next", 32'(vob[0]), 32'd1);
        chk("T6 post-reset sel_out0", 32'(sob[1:0]), 32'd0);
        post(0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
